// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory responder: byte-lane bundle, FSM states
// and lane/word conversion helpers.
package mips_mem_pkg;

  // Four byte lanes, lane 0 is the most significant byte of the word.
  typedef logic [0:3][7:0] byte_lanes_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  function automatic logic [31:0] lanes_to_word(input byte_lanes_t lanes);
    return {lanes[0], lanes[1], lanes[2], lanes[3]};
  endfunction

  function automatic byte_lanes_t word_to_lanes(input logic [31:0] word);
    byte_lanes_t lanes;
    lanes[0] = word[31:24];
    lanes[1] = word[23:16];
    lanes[2] = word[15:8];
    lanes[3] = word[7:0];
    return lanes;
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word-wide storage: one write port, one combinational read port for the core
// and one registered read port used by the dump streamer.
module mips_mem_array #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o,
  input  logic             dump_en_i,
  input  logic [IDX_W-1:0] dump_idx_i,
  output logic [31:0]      dump_data_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] dump_data_q;

  // Contents are deliberately not reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dump_data_q <= '0;
    end else if (dump_en_i) begin
      dump_data_q <= mem_q[dump_idx_i];
    end
  end

  assign dump_data_o = dump_data_q;

endmodule

// File: rtl/mips_data_memory.sv
// Data-memory responder for the single-cycle MIPS core: combinational loads,
// posted stores with forwarding, and a post-halt drain + full-array dump.
module mips_data_memory
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [31:0]          mem_addr,
  input  byte_lanes_t          mem_data_in,
  input  logic                 mem_write_en,
  input  logic                 halted,
  output byte_lanes_t          mem_data_out,
  output logic                 mem_error,
  output logic                 dump_valid,
  output logic [ADDR_BITS-1:0] dump_addr,
  output logic [31:0]          dump_data,
  output logic                 dump_done,
  output mem_state_t           dbg_state
);

  localparam int IDX_W = ADDR_BITS - 2;
  localparam int WORDS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  mem_state_t           state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [IDX_W-1:0]     wr_idx_q;
  byte_lanes_t          wr_data_q;
  logic                 mem_error_q, mem_error_d;
  logic                 dump_valid_q, dump_valid_d;
  logic [ADDR_BITS-1:0] dump_addr_q, dump_addr_d;
  logic                 dump_done_q, dump_done_d;
  logic                 dump_en;

  logic [IDX_W-1:0] acc_idx;
  logic             acc_legal;
  logic             in_run;
  logic             store_ok;
  logic             fwd_hit;
  logic [31:0]      arr_rd_word;

  assign acc_idx   = mem_addr[ADDR_BITS-1:2];
  assign acc_legal = (mem_addr[1:0] == 2'b00) && (mem_addr[31:ADDR_BITS] == '0);
  assign in_run    = (state_q == RUN);
  assign store_ok  = in_run && !halted && mem_write_en && acc_legal;
  assign fwd_hit   = wr_valid_q && (wr_idx_q == acc_idx);

  mips_mem_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk         (clk),
    .rst_b       (rst_b),
    .wr_en_i     (wr_valid_q),
    .wr_idx_i    (wr_idx_q),
    .wr_data_i   (lanes_to_word(wr_data_q)),
    .rd_idx_i    (acc_idx),
    .rd_data_o   (arr_rd_word),
    .dump_en_i   (dump_en),
    .dump_idx_i  (cnt_q),
    .dump_data_o (dump_data)
  );

  // A pending posted store shadows the array word it targets.
  always_comb begin
    mem_data_out = '0;
    if (in_run && acc_legal) begin
      mem_data_out = fwd_hit ? wr_data_q : word_to_lanes(arr_rd_word);
    end
  end

  always_comb begin
    wr_valid_d  = store_ok;
    mem_error_d = mem_error_q | (in_run && !acc_legal);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dump_valid_d = 1'b0;
    dump_addr_d  = dump_addr_q;
    dump_done_d  = dump_done_q;
    dump_en      = 1'b0;
    case (state_q)
      RUN: begin
        if (halted) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d   = '0;
        state_d = DUMP;
      end
      DUMP: begin
        dump_en      = 1'b1;
        dump_valid_d = 1'b1;
        dump_addr_d  = {cnt_q, 2'b00};
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        dump_done_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      wr_valid_q   <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      mem_error_q  <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_valid_q   <= wr_valid_d;
      mem_error_q  <= mem_error_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_done_q  <= dump_done_d;
      if (store_ok) begin
        wr_idx_q  <= acc_idx;
        wr_data_q <= mem_data_in;
      end
    end
  end

  assign mem_error  = mem_error_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_done  = dump_done_q;
  assign dbg_state  = state_q;

endmodule
